// File: rtl/serdesphy_top.sv
// Single-lane SerDes PHY: 8N1 framing serializer, 2-flop synchronized deframer,
// internal TX->RX loopback, TinyTapeout-style pinout.
module serdesphy_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

  logic tx_load, rx_serial_in, loopback, err_clear;
  assign tx_load      = uio_in[0];
  assign rx_serial_in = uio_in[1];
  assign loopback     = uio_in[2];
  assign err_clear    = uio_in[3];

  logic unused;
  assign unused = ^uio_in[7:4];

  // TX: shift register holds {stop, data}; the start bit goes straight to the line
  tx_state_t  tx_state, tx_state_nx;
  logic [8:0] tx_shift, tx_shift_nx;
  logic [3:0] tx_cnt, tx_cnt_nx;
  logic       tx_line, tx_line_nx;

  always_comb begin
    tx_state_nx = tx_state;
    tx_shift_nx = tx_shift;
    tx_cnt_nx   = tx_cnt;
    tx_line_nx  = tx_line;
    case (tx_state)
      TX_IDLE: begin
        if (tx_load && ena) begin
          tx_state_nx = TX_SEND;
          tx_shift_nx = {1'b1, ui_in};
          tx_cnt_nx   = '0;
          tx_line_nx  = 1'b0;
        end
      end
      TX_SEND: begin
        tx_line_nx  = tx_shift[0];
        tx_shift_nx = {1'b1, tx_shift[8:1]};
        tx_cnt_nx   = tx_cnt + 4'd1;
        if (tx_cnt == 4'd9) begin
          tx_state_nx = TX_IDLE;
          tx_cnt_nx   = '0;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_shift <= tx_shift_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_line  <= tx_line_nx;
    end
  end

  // RX: loopback shares the synchronizer so both sources see identical latency
  logic sync1, sync2, rx_s;
  assign rx_s = sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= loopback ? tx_line : rx_serial_in;
      sync2 <= sync1;
    end
  end

  rx_state_t  rx_state, rx_state_nx;
  logic [2:0] rx_cnt, rx_cnt_nx;
  logic [7:0] rx_byte, rx_byte_nx;
  logic [7:0] rx_data, rx_data_nx;
  logic       rx_valid, rx_valid_nx;
  logic       rx_err, rx_err_nx;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_byte_nx  = rx_byte;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    rx_err_nx   = err_clear ? 1'b0 : rx_err;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = RX_DATA;
          rx_cnt_nx   = '0;
        end
      end
      RX_DATA: begin
        rx_byte_nx = {rx_s, rx_byte[7:1]};
        rx_cnt_nx  = rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) rx_state_nx = RX_STOP;
      end
      RX_STOP: begin
        rx_state_nx = RX_IDLE;
        if (rx_s) begin
          rx_data_nx  = rx_byte;
          rx_valid_nx = 1'b1;
        end else begin
          rx_err_nx = 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_byte  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_byte  <= rx_byte_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      rx_err   <= rx_err_nx;
    end
  end

  assign uo_out  = rx_data;
  assign uio_out = {rx_err, rx_valid, (tx_state == TX_SEND), tx_line, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_serdesphy_top.sv
// Randomized self-checking bench for serdesphy_top against a frame-level reference model.
module tb_serdesphy_top;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in;
  logic       load, rx_in, lb, eclr;

  assign uio_in = {4'b0000, eclr, lb, rx_in, load};

  serdesphy_top dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_uo;
  logic       exp_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_line"},  8'(uio_out[4]), 8'h01);
    chk({tag, "_busy"},  8'(uio_out[5]), 8'h00);
    chk({tag, "_valid"}, 8'(uio_out[6]), 8'h00);
  endtask

  // k counts edges after the load edge; the model is the 8N1 frame plus a fixed
  // 12-edge loopback latency to the received byte.
  task automatic do_frame(input logic [7:0] b, input int last_k, input int pend_k,
                          input logic [7:0] pend_b, input int glitch_k);
    logic el, eb, ev;
    ui_in = b;
    load  = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      tick();
      if (k == 0) load = 1'b0;
      if (k == glitch_k) begin load = 1'b1; ui_in = 8'h3C; end
      if (k == glitch_k + 1) load = 1'b0;
      if (k == 0)      el = 1'b0;
      else if (k <= 8) el = b[k-1];
      else             el = 1'b1;
      eb = (k <= 9);
      ev = (k == 12) || (k == pend_k);
      if (k == pend_k) exp_uo = pend_b;
      if (k == 12)     exp_uo = b;
      chk("tx_line",  8'(uio_out[4]), 8'(el));
      chk("tx_busy",  8'(uio_out[5]), 8'(eb));
      chk("rx_valid", 8'(uio_out[6]), 8'(ev));
      chk("uo_out",   uo_out, exp_uo);
      chk("rx_err",   8'(uio_out[7]), 8'(exp_err));
    end
  endtask

  // j indexes the externally driven bit; rx decision lands after edge j=11.
  task automatic ext_frame(input logic [7:0] b, input logic stopbit);
    for (int j = 0; j <= 13; j++) begin
      if (j == 0)      rx_in = 1'b0;
      else if (j <= 8) rx_in = b[j-1];
      else if (j == 9) rx_in = stopbit;
      else             rx_in = 1'b1;
      tick();
      if (j == 11) begin
        if (stopbit) exp_uo = b;
        else         exp_err = 1'b1;
      end
      chk("ext_valid", 8'(uio_out[6]), 8'((j == 11) && stopbit));
      chk("ext_uo",    uo_out, exp_uo);
      chk("ext_err",   8'(uio_out[7]), 8'(exp_err));
    end
    rx_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    rst = 1'b1; ena = 1'b1; load = 1'b0; rx_in = 1'b1; lb = 1'b0; eclr = 1'b0;
    ui_in = 8'h00;
    exp_uo = 8'h00; exp_err = 1'b0;
    #1;
    chk("rst_uo",  uo_out,  8'h00);
    chk("rst_uio", uio_out, 8'h10);
    chk("rst_oe",  uio_oe,  8'hF0);
    #12 rst = 1'b0;
    tick();
    tick();
    chk_idle("post_rst");

    lb = 1'b1;
    do_frame(8'hA5, 13, -1, 8'h00, -1);

    do_frame(8'h00, 10, -1, 8'h00, -1);
    do_frame(8'hFF, 13, 1, 8'h00, -1);

    do_frame(8'h81, 13, -1, 8'h00, 3);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_idle("no_second");
      chk("no_second_uo", uo_out, 8'h81);
    end

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      do_frame(rb, 13, -1, 8'h00, -1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick();
        chk_idle("gap");
      end
    end

    lb = 1'b0;
    tick();
    tick();
    ext_frame(8'h5A, 1'b0);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    exp_err = 1'b0;
    chk("err_clear", 8'(uio_out[7]), 8'h00);
    ext_frame(8'h5A, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      ext_frame(rb, rs);
    end
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    exp_err = 1'b0;
    chk("err_clear2", 8'(uio_out[7]), 8'h00);

    ena = 1'b0;
    load = 1'b1;
    ui_in = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("ena_off");
    end
    load = 1'b0;
    ena = 1'b1;

    lb = 1'b1;
    ui_in = 8'h77;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("mid_busy", 8'(uio_out[5]), 8'h01);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    exp_uo = 8'h00;
    chk("mid_rst_uio", uio_out, 8'h10);
    chk("mid_rst_uo",  uo_out,  8'h00);
    #3 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_abort_uio", uio_out, 8'h10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
